// File: rtl/demo1_helloworld_ram_burst_adapter.sv
// Avalon-MM burst adapter in front of the single-port on-chip RAM.
// Splits incrementing read/write bursts into one RAM access per cycle and
// regenerates readdatavalid from the RAM's one-cycle read latency.
// Optional feature macro: RAM_ADAPTER_RANGE_CHECK_EN (suppress accesses at
// word addresses >= DEPTH, return zero data for them, raise sticky err).
module demo1_helloworld_ram_burst_adapter #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DEPTH     = 2560,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned BURST_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [BURST_W-1:0] s_burstcount,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [31:0]       s_writedata,
  input  logic [3:0]        s_byteenable,
  output logic              s_waitrequest,
  output logic [31:0]       s_readdata,
  output logic              s_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic              m_clken,
  input  logic [31:0]       m_readdata,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  state_t             state_q, state_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] len_c;

  logic               iss_rd, iss_wr, oor_c;
  logic [ADDR_W-1:0]  iss_addr;
  logic [ADDR_W-1:0]  m_address_d;
  logic [3:0]         m_byteenable_d;
  logic               m_chipselect_d, m_write_d;
  logic [31:0]        m_writedata_d;
  logic               rd_issue_q, rd_issue_d;
  logic               rd_oor_q, rd_oor_d, rd_zero_q;
  logic               err_q, err_d;

`ifndef RAM_ADAPTER_RANGE_CHECK_EN
  localparam int unsigned unused_depth = DEPTH;
`endif

  // Effective burst length: 0 means 1, anything above MAX_BURST is clamped.
  always_comb begin
    if (s_burstcount == '0)
      len_c = BURST_W'(1);
    else if (s_burstcount > BURST_W'(MAX_BURST))
      len_c = BURST_W'(MAX_BURST);
    else
      len_c = s_burstcount;
  end

  // Next state, burst counters and the RAM access to present next cycle.
  // cnt holds accesses still to be issued after the one being presented.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    iss_rd   = 1'b0;
    iss_wr   = 1'b0;
    iss_addr = addr_q;
    oor_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s_write) begin
          iss_wr   = 1'b1;
          iss_addr = s_address;
          addr_d   = s_address + ADDR_W'(1);
          cnt_d    = len_c - BURST_W'(1);
          if (len_c > BURST_W'(1)) state_d = WR_BURST;
        end else if (s_read) begin
          iss_rd   = 1'b1;
          iss_addr = s_address;
          addr_d   = s_address + ADDR_W'(1);
          cnt_d    = len_c - BURST_W'(1);
          state_d  = RD_BURST;
        end
      end
      RD_BURST: begin
        if (cnt_q != '0) begin
          iss_rd = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - BURST_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      WR_BURST: begin
        if (s_write) begin
          iss_wr = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - BURST_W'(1);
          if (cnt_q == BURST_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef RAM_ADAPTER_RANGE_CHECK_EN
    oor_c = (iss_rd || iss_wr) && (32'(iss_addr) >= DEPTH);
`endif

    m_address_d    = (iss_rd || iss_wr) ? iss_addr : m_address;
    m_chipselect_d = (iss_rd || iss_wr) && !oor_c;
    m_write_d      = iss_wr && !oor_c;
    m_writedata_d  = iss_wr ? s_writedata : '0;
    m_byteenable_d = iss_wr ? s_byteenable : (iss_rd ? 4'hF : 4'h0);
    rd_issue_d     = iss_rd;
    rd_oor_d       = iss_rd && oor_c;
    err_d          = err_q || oor_c;
  end

  // State, counters, RAM-side outputs and the read-return pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      addr_q          <= '0;
      m_address       <= '0;
      m_byteenable    <= '0;
      m_chipselect    <= 1'b0;
      m_write         <= 1'b0;
      m_writedata     <= '0;
      rd_issue_q      <= 1'b0;
      rd_oor_q        <= 1'b0;
      rd_zero_q       <= 1'b0;
      s_readdatavalid <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      m_address       <= m_address_d;
      m_byteenable    <= m_byteenable_d;
      m_chipselect    <= m_chipselect_d;
      m_write         <= m_write_d;
      m_writedata     <= m_writedata_d;
      rd_issue_q      <= rd_issue_d;
      rd_oor_q        <= rd_oor_d;
      rd_zero_q       <= rd_oor_q;
      s_readdatavalid <= rd_issue_q;
      err_q           <= err_d;
    end
  end

  // Read data passes straight through; zeroed outside valid cycles and for
  // suppressed out-of-range reads.
  assign s_readdata    = (s_readdatavalid && !rd_zero_q) ? m_readdata : '0;
  assign s_waitrequest = (state_q == RD_BURST);
  assign m_clken       = 1'b1;
  assign err           = err_q;

endmodule

// File: tb/tb_demo1_helloworld_ram_burst_adapter.sv
// Self-checking bench: per-cycle expectation tables built from the burst
// rules, a RAM model behind the adapter, and literal spot checks.
module tb_demo1_helloworld_ram_burst_adapter;

  localparam int NC = 1024;
`ifdef RAM_ADAPTER_RANGE_CHECK_EN
  localparam bit RANGE = 1'b1;
`else
  localparam bit RANGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] s_address;
  logic [3:0]  s_burstcount;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest, s_readdatavalid;
  logic [31:0] s_readdata;
  logic [11:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect, m_write, m_clken, err;
  logic [31:0] m_writedata, m_readdata;

  demo1_helloworld_ram_burst_adapter dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_burstcount(s_burstcount),
    .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_byteenable(m_byteenable),
    .m_chipselect(m_chipselect), .m_write(m_write),
    .m_writedata(m_writedata), .m_clken(m_clken),
    .m_readdata(m_readdata), .err(err)
  );

  always #5 clk = ~clk;

  // RAM behind the adapter: one-cycle read latency, byte-lane writes.
  logic [31:0] ram [0:4095];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (m_clken && m_chipselect) begin
      if (m_write) begin
        for (int b = 0; b < 4; b++)
          if (m_byteenable[b]) ram[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[m_address];
      end
    end
  end
  assign m_readdata = ram_q;

  // Checker model: golden memory and expected outputs per cycle.
  logic [31:0] gold [0:4095];
  bit          e_wait [0:NC-1];
  bit          e_cs   [0:NC-1];
  bit          e_we   [0:NC-1];
  bit          e_rv   [0:NC-1];
  logic [11:0] e_addr [0:NC-1];
  logic [31:0] e_wd   [0:NC-1];
  logic [3:0]  e_be   [0:NC-1];
  logic [31:0] e_rd   [0:NC-1];
  int          err_cyc = 1 << 30;

  int  cyc = 0;
  bit  run = 1'b0;
  int  checks = 0;
  int  errors = 0;
  logic [31:0] got [$];
  logic [11:0] got_addr [$];
  logic [5:0]  ev, av;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int len_of(input logic [3:0] bc);
    if (bc == 4'd0) return 1;
    if (bc > 4'd8) return 8;
    return int'(bc);
  endfunction

  function automatic bit is_oor(input logic [11:0] a);
    return RANGE && (int'(a) >= 2560);
  endfunction

  // Read of n words accepted at the edge ending cycle k.
  task automatic model_read(input int k, input logic [11:0] a, input int n);
    logic [11:0] ad;
    for (int i = 0; i < n; i++) begin
      ad = a + 12'(i);
      e_wait[k+1+i] = 1'b1;
      e_cs[k+1+i]   = !is_oor(ad);
      e_addr[k+1+i] = ad;
      e_rv[k+2+i]   = 1'b1;
      e_rd[k+2+i]   = is_oor(ad) ? 32'h0 : gold[ad];
      if (is_oor(ad) && (k + 1 + i) < err_cyc) err_cyc = k + 1 + i;
    end
  endtask

  task automatic model_write(input int k, input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    e_cs[k+1] = !is_oor(a);
    e_we[k+1] = !is_oor(a);
    e_addr[k+1] = a;
    e_wd[k+1] = d;
    e_be[k+1] = be;
    if (is_oor(a)) begin
      if (k + 1 < err_cyc) err_cyc = k + 1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (be[b]) gold[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic model_clear(input int from);
    for (int c = from; c < NC; c++) begin
      e_wait[c] = 0; e_cs[c] = 0; e_we[c] = 0; e_rv[c] = 0;
    end
    err_cyc = 1 << 30;
  endtask

  // Per-cycle comparison against the model, plus capture of returned data.
  always @(negedge clk) begin
    if (run && reset_n) begin
      ev = {1'b1, e_wait[cyc], e_cs[cyc], e_we[cyc], e_rv[cyc], (cyc >= err_cyc)};
      av = {m_clken, s_waitrequest, m_chipselect, m_write, s_readdatavalid, err};
      chk("ctrl{clken,wait,cs,we,rv,err}", 32'(av), 32'(ev));
      if (e_cs[cyc]) chk("m_address", 32'(m_address), 32'(e_addr[cyc]));
      if (e_we[cyc]) begin
        chk("m_writedata", m_writedata, e_wd[cyc]);
        chk("m_byteenable", 32'(m_byteenable), 32'(e_be[cyc]));
      end
      if (e_rv[cyc]) chk("s_readdata", s_readdata, e_rd[cyc]);
      if (s_readdatavalid) got.push_back(s_readdata);
      if (s_waitrequest) got_addr.push_back(m_address);
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic settle;
    @(negedge clk); #1;
  endtask

  task automatic do_read(input logic [11:0] a, input logic [3:0] bc);
    int n;
    n = len_of(bc);
    got.delete(); got_addr.delete();
    s_address = a; s_burstcount = bc; s_read = 1'b1;
    model_read(cyc, a, n);
    tick;
    s_read = 1'b0;
    repeat (n) tick;
    settle;
  endtask

  task automatic wr_beat(input logic [11:0] a, input logic [3:0] bc, input logic [31:0] d,
                         input logic [3:0] be, input bit first);
    s_write = 1'b1; s_address = first ? a : ~a; s_burstcount = bc;
    s_writedata = d; s_byteenable = be;
    model_write(cyc, a, d, be);
    tick;
    s_write = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, 32'({s_waitrequest, s_readdatavalid, m_chipselect, m_write, err}), 32'h0);
    chk({tag, "_clken"}, 32'(m_clken), 32'h1);
    chk({tag, "_addr"}, 32'(m_address), 32'h0);
    chk({tag, "_be"}, 32'(m_byteenable), 32'h0);
    chk({tag, "_wd"}, m_writedata, 32'h0);
    chk({tag, "_rdata"}, s_readdata, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]  = 32'hC0DE_0000 | 32'(i);
      gold[i] = 32'hC0DE_0000 | 32'(i);
    end
    ram[0] = 32'h0; gold[0] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      ram[16+i]  = 32'hA0 + 32'(i);
      gold[16+i] = 32'hA0 + 32'(i);
    end
    model_clear(0);
    reset_n = 1'b0; s_address = '0; s_burstcount = '0; s_read = 1'b0;
    s_write = 1'b0; s_writedata = '0; s_byteenable = '0;
    repeat (3) tick;
    chk_reset_outputs("reset");
    reset_n = 1'b1; run = 1'b1;
    tick;

    // Read burst of 4 from preloaded words.
    do_read(12'h010, 4'd4);
    chk("rd4_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      chk("rd4_d0", got[0], 32'hA0); chk("rd4_d1", got[1], 32'hA1);
      chk("rd4_d2", got[2], 32'hA2); chk("rd4_d3", got[3], 32'hA3);
    end
    chk("rd4_wait_cycles", 32'(got_addr.size()), 32'd4);

    // Write burst of 3 with an idle gap after the first beat, then read back.
    wr_beat(12'h100, 4'd3, 32'h11, 4'hF, 1'b1);
    tick;
    wr_beat(12'h101, 4'd3, 32'h22, 4'hF, 1'b0);
    wr_beat(12'h102, 4'd3, 32'h33, 4'hF, 1'b0);
    tick;
    do_read(12'h100, 4'd3);
    chk("wr3_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("wr3_d0", got[0], 32'h11); chk("wr3_d1", got[1], 32'h22);
      chk("wr3_d2", got[2], 32'h33);
    end

    // Single-lane write into a zero word.
    wr_beat(12'h000, 4'd1, 32'hDEADBEEF, 4'b0010, 1'b1);
    do_read(12'h000, 4'd1);
    chk("be_count", 32'(got.size()), 32'd1);
    if (got.size() == 1) chk("be_data", got[0], 32'h0000BE00);

    // Burst length edges.
    do_read(12'h020, 4'd0);
    chk("len0_count", 32'(got.size()), 32'd1);
    if (got.size() == 1) chk("len0_data", got[0], 32'hC0DE0020);
    do_read(12'h030, 4'd15);
    chk("len15_count", 32'(got.size()), 32'd8);
    if (got_addr.size() == 8) chk("len15_last_addr", 32'(got_addr[7]), 32'h037);

    // Simultaneous read and write in IDLE: only the write happens.
    s_read = 1'b1;
    wr_beat(12'h040, 4'd1, 32'h12345678, 4'hF, 1'b1);
    s_read = 1'b0;
    do_read(12'h040, 4'd1);
    if (got.size() == 1) chk("rw_prio_data", got[0], 32'h12345678);
    else chk("rw_prio_count", 32'(got.size()), 32'd1);

    // Back-to-back reads with no gap between bursts.
    do_read(12'h010, 4'd2);
    do_read(12'h012, 4'd2);
    if (got.size() == 2) chk("b2b_d0", got[0], 32'hA2);
    else chk("b2b_count", 32'(got.size()), 32'd2);

    // Read across the populated-depth boundary.
    do_read(12'h9FE, 4'd4);
    chk("range_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      chk("range_d0", got[0], 32'hC0DE09FE);
      chk("range_d1", got[1], 32'hC0DE09FF);
      chk("range_d2", got[2], RANGE ? 32'h0 : 32'hC0DE0A00);
      chk("range_d3", got[3], RANGE ? 32'h0 : 32'hC0DE0A01);
    end
    chk("range_err", 32'(err), 32'(RANGE));

    // Address wrap at the top of the address space.
    do_read(12'hFFE, 4'd4);
    if (got_addr.size() == 4) begin
      chk("wrap_a0", 32'(got_addr[0]), 32'hFFE); chk("wrap_a1", 32'(got_addr[1]), 32'hFFF);
      chk("wrap_a2", 32'(got_addr[2]), 32'h000); chk("wrap_a3", 32'(got_addr[3]), 32'h001);
    end else chk("wrap_count", 32'(got_addr.size()), 32'd4);

    // Reset during the second beat of an 8-beat read.
    got.delete();
    s_address = 12'h010; s_burstcount = 4'd8; s_read = 1'b1;
    model_read(cyc, 12'h010, 8);
    tick;
    s_read = 1'b0;
    tick;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_clear(cyc);
    tick; tick;
    reset_n = 1'b1;
    repeat (4) tick;
    settle;
    chk("midrst_no_stray_rv", 32'(got.size()), 32'd0);
    do_read(12'h011, 4'd2);
    chk("post_rst_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) chk("post_rst_d0", got[0], 32'hA1);

    tick;
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
